cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//   Sits between the I-cache and D-cache controllers and the single multi-cycle main
//   memory. Arbitrates block-fill requests from both caches and D-cache write-through
//   stores. Sequences the 8 word reads of a 16-byte block fill and streams returned
//   words back to the owning cache with write-enable, word address and tag-write strobes.
// PARAMETERS
//   ADDR_W   16  byte address width
//   DATA_W   16  memory/cache word width
//   WORDS    8   words per cache block (block = 2*WORDS bytes, 16 B)
//   MEM_LAT  4   cycles from mem_en read issue to matching mem_data_valid
// PORTS
//   clk               in   1       clock
//   rst_n             in   1       synchronous active-low reset
//   i_miss            in   1       I-cache miss request, held until i_write_tag
//   i_miss_addr       in   ADDR_W  I-cache missed byte address
//   i_stall           out  1       I-side stall
//   i_write_data      out  1       I-cache data-array write strobe, one word
//   i_write_tag       out  1       I-cache tag/meta write strobe, last word of fill
//   d_miss            in   1       D-cache miss request, held until d_write_tag
//   d_miss_addr       in   ADDR_W  D-cache missed byte address
//   d_stall           out  1       D-side stall
//   d_write_data      out  1       D-cache data-array write strobe
//   d_write_tag       out  1       D-cache tag/meta write strobe
//   fill_addr         out  ADDR_W  byte address of the word being returned
//   fill_data         out  DATA_W  returned word, shared by both caches
//   d_wr              in   1       D-cache write-through store request
//   d_wr_addr         in   ADDR_W  store address
//   d_wr_data         in   DATA_W  store data
//   d_wr_ack          out  1       store accepted this cycle
//   mem_en            out  1       memory access enable
//   mem_wr            out  1       1=write, 0=read
//   mem_addr          out  ADDR_W  memory address
//   mem_wdata         out  DATA_W  memory write data
//   mem_rdata         in   DATA_W  memory read data
//   mem_data_valid    in   1       mem_rdata valid; in order, MEM_LAT after issue
// BEHAVIOUR
//   - Reset: state IDLE, counters 0, last_grant=I. All outputs 0.
//   - States: IDLE, FILL. An owner register (I/D) is valid only in FILL.
//   - IDLE arbitration, in priority order:
//     (1) d_wr: mem_en=1, mem_wr=1, mem_addr/mem_wdata=d_wr_*, d_wr_ack=1, all combinational
//         in that cycle. Remain in IDLE.
//     (2) A single miss goes to FILL with that owner.
//     (3) If both miss, the side not equal to last_grant wins. last_grant updates on grant.
//     A miss coincident with d_wr is granted on a later IDLE cycle.
//   - Entering FILL latches base = miss_addr with bits [3:0] cleared and zeroes
//     issue_cnt and rcv_cnt.
//   - FILL issue: while issue_cnt<WORDS, drive mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt
//     and increment. This gives one read per cycle, WORDS consecutive cycles.
//   - FILL return: each mem_data_valid drives fill_data=mem_rdata and
//     fill_addr=base+2*rcv_cnt, pulses owner's *_write_data, and increments rcv_cnt.
//     When rcv_cnt==WORDS-1 with valid, the owner's *_write_tag is also pulsed and the
//     block goes to IDLE next cycle.
//   - Fill latency: miss sampled in IDLE at cycle t.
//     - Reads issue in cycles t+1..t+WORDS.
//     - Data returns in cycles t+1+MEM_LAT..t+WORDS+MEM_LAT.
//     - write_tag is asserted at t+WORDS+MEM_LAT.
//   - Stall signals are combinational:
//     - x_stall = x_miss | (FILL & owner==x).
//     - d_stall is also 1 while d_wr is pending and not acked.
//   - No abort: if the owner drops its miss mid-fill, the fill still completes all WORDS.
//     The other side's miss and d_wr wait. d_wr_ack=0 in FILL.
//   - mem_data_valid in IDLE is ignored: no strobes, no counter change.
//   - Reset mid-fill returns to IDLE immediately. Late memory returns are ignored.
//   - Address arithmetic is mod 2^ADDR_W. The block base is aligned, so there is no
//     carry out of bits [3:0].
// TESTING
//   - I miss, addr 0x1236:
//     - mem reads 0x1230,0x1232..0x123E in 8 consecutive cycles.
//     - 8 i_write_data pulses with fill_addr 0x1230..0x123E.
//     - i_write_tag on the 8th, 12 cycles after grant; i_stall falls after.
//   - Simultaneous i_miss and d_miss after reset (last_grant=I):
//     - D is filled first, then I.
//     - Then both again: D first once more; verify alternation thereafter.
//   - d_wr 0x0040/0xBEEF in IDLE:
//     - same cycle mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_wr_ack=1.
//     - d_wr raised during an I fill: ack=0 until fill ends, then acked before pending d_miss.
//   - D fill with d_miss dropped after 3rd word:
//     - all 8 d_write_data pulses and d_write_tag still occur.
//     - no i_write_* pulses.
//   - rst_n low at 5th issued read:
//     - all outputs 0 next cycle, state IDLE.
//     - 4 subsequent stray mem_data_valid pulses produce no strobes.
//   - Miss addr 0xFFFF: base 0xFFF0, last fill_addr 0xFFFE, no wrap into 0x0000.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle memory between the I/D cache controllers:
// block fills for either side plus D-side write-through stores.
module cache_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    output logic              i_stall,
    output logic              i_write_data,
    output logic              i_write_tag,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              d_stall,
    output logic              d_write_data,
    output logic              d_write_tag,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS - 1);

    typedef enum logic { IDLE, FILL } state_t;
    typedef enum logic { OWN_I, OWN_D } side_t;

    state_t            state;
    side_t             owner;
    side_t             last_grant;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rcv_cnt;
    logic [MEM_LAT-1:0] rd_pipe;

    logic              in_idle;
    logic              in_fill;
    logic              wr_go;
    logic              grant;
    logic              grant_d;
    logic              issuing;
    logic              rcv;
    logic              rcv_last;
    logic [ADDR_W-1:0] sel_addr;

    // Everything observable is held low while reset is asserted.
    assign in_idle = rst_n && (state == IDLE);
    assign in_fill = rst_n && (state == FILL);

    assign wr_go   = in_idle && d_wr;
    assign grant   = in_idle && !d_wr && (i_miss || d_miss);
    assign grant_d = d_miss && (!i_miss || (last_grant == OWN_I));
    assign sel_addr = grant_d ? d_miss_addr : i_miss_addr;

    assign issuing = in_fill && (issue_cnt < CNT_W'(WORDS));

    // rd_pipe marks cycles where a return from this fill is due, so
    // returns left over from an aborted fill can never be consumed.
    assign rcv      = in_fill && mem_data_valid && rd_pipe[MEM_LAT-1];
    assign rcv_last = rcv && (rcv_cnt == CNT_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            base       <= '0;
            issue_cnt  <= '0;
            rcv_cnt    <= '0;
            rd_pipe    <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | MEM_LAT'(issuing);
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= FILL;
                        owner      <= grant_d ? OWN_D : OWN_I;
                        last_grant <= grant_d ? OWN_D : OWN_I;
                        base       <= sel_addr & ~OFF_MASK;
                        issue_cnt  <= '0;
                        rcv_cnt    <= '0;
                    end
                end
                FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (rcv) begin
                        rcv_cnt <= rcv_cnt + CNT_W'(1);
                    end
                    if (rcv_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_go) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
        end else if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = base + (ADDR_W'(issue_cnt) << 1);
        end
    end

    always_comb begin
        fill_data = '0;
        fill_addr = '0;
        if (rcv) begin
            fill_data = mem_rdata;
            fill_addr = base + (ADDR_W'(rcv_cnt) << 1);
        end
    end

    assign d_wr_ack     = wr_go;
    assign i_write_data = rcv && (owner == OWN_I);
    assign d_write_data = rcv && (owner == OWN_D);
    assign i_write_tag  = rcv_last && (owner == OWN_I);
    assign d_write_tag  = rcv_last && (owner == OWN_D);

    assign i_stall = rst_n && (i_miss || (in_fill && owner == OWN_I));
    assign d_stall = rst_n && (d_miss || (in_fill && owner == OWN_D) ||
                               (d_wr && !wr_go));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed stimulus queues
// expected memory accesses and fill strobes; a negedge monitor checks them.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0;
    logic [15:0] i_miss_addr = '0;
    logic        i_stall, i_write_data, i_write_tag;
    logic        d_miss = 1'b0;
    logic [15:0] d_miss_addr = '0;
    logic        d_stall, d_write_data, d_write_tag;
    logic [15:0] fill_addr, fill_data;
    logic        d_wr = 1'b0;
    logic [15:0] d_wr_addr = '0;
    logic [15:0] d_wr_data = '0;
    logic        d_wr_ack, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr), .i_stall(i_stall),
        .i_write_data(i_write_data), .i_write_tag(i_write_tag),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr), .d_stall(d_stall),
        .d_write_data(d_write_data), .d_write_tag(d_write_tag),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .d_wr_ack(d_wr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed 4-cycle read latency, data = addr ^ 5A5A.
    logic [3:0]  pv = '0;
    logic [15:0] pd [4];
    logic        stray_v = 1'b0;
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en && !mem_wr};
        pd[0] <= mem_addr ^ 16'h5A5A;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign mem_data_valid = pv[3] | stray_v;
    assign mem_rdata      = pv[3] ? pd[3] : 16'hDEAD;

    typedef struct packed {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_rec_t;

    typedef struct packed {
        int          cyc;
        logic        iw, dw, it, dt;
        logic [15:0] addr;
        logic [15:0] data;
    } fill_rec_t;

    mem_rec_t  mem_q[$];
    fill_rec_t fill_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Miss granted (sampled in IDLE) in cycle t.
    task automatic exp_fill(input bit d, input logic [15:0] a, input int t);
        logic [15:0] b;
        logic [15:0] wa;
        b = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            wa = b + 16'(2 * k);
            mem_q.push_back('{cyc: t + 1 + k, wr: 1'b0, addr: wa, data: 16'h0});
            fill_q.push_back('{cyc: t + 5 + k, iw: !d, dw: d,
                               it: (!d && k == 7), dt: (d && k == 7),
                               addr: wa, data: wa ^ 16'h5A5A});
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] v,
                          input int t);
        mem_q.push_back('{cyc: t, wr: 1'b1, addr: a, data: v});
    endtask

    mem_rec_t  mg;
    fill_rec_t fg;
    always @(negedge clk) begin
        if (mem_en) begin
            mg = '{cyc: cyc, wr: mem_wr, addr: mem_addr,
                   data: mem_wr ? mem_wdata : 16'h0};
            if (mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: got %h expected none", mg);
            end else begin
                check($sformatf("mem@%0d", cyc), mg, mem_q.pop_front());
            end
        end
        if (i_write_data || d_write_data || i_write_tag || d_write_tag) begin
            fg = '{cyc: cyc, iw: i_write_data, dw: d_write_data,
                   it: i_write_tag, dt: d_write_tag,
                   addr: fill_addr, data: fill_data};
            if (fill_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fill_unexpected: got %h expected none", fg);
            end else begin
                check($sformatf("fill@%0d", cyc), fg, fill_q.pop_front());
            end
        end
    end

    function automatic logic [127:0] all_outs();
        return {i_stall, i_write_data, i_write_tag, d_stall, d_write_data,
                d_write_tag, fill_addr, fill_data, d_wr_ack, mem_en, mem_wr,
                mem_addr, mem_wdata};
    endfunction

    initial begin
        // Reset state
        goto(2);
        @(negedge clk);
        check("outs_in_reset", all_outs(), '0);
        goto(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("outs_after_reset", all_outs(), '0);

        // I miss at 0x1236
        goto(5);
        i_miss = 1'b1;
        i_miss_addr = 16'h1236;
        exp_fill(1'b0, 16'h1236, 5);
        @(negedge clk);
        check("i_stall_on_miss", i_stall, 1'b1);
        goto(18);
        i_miss = 1'b0;
        @(negedge clk);
        check("i_stall_after_fill", i_stall, 1'b0);

        // Simultaneous misses, last_grant=I: D first, then I
        goto(20);
        i_miss = 1'b1;
        i_miss_addr = 16'h1B1E;
        d_miss = 1'b1;
        d_miss_addr = 16'h0A08;
        exp_fill(1'b1, 16'h0A08, 20);
        exp_fill(1'b0, 16'h1B1E, 33);
        goto(33);
        d_miss = 1'b0;
        goto(46);
        i_miss = 1'b0;

        // Both again: D first once more
        goto(48);
        i_miss = 1'b1;
        i_miss_addr = 16'h3334;
        d_miss = 1'b1;
        d_miss_addr = 16'h2222;
        exp_fill(1'b1, 16'h2222, 48);
        exp_fill(1'b0, 16'h3334, 61);
        goto(61);
        d_miss = 1'b0;
        goto(74);
        i_miss = 1'b0;

        // Tie with last=I -> D, then tie with last=D -> I, then D
        goto(76);
        i_miss = 1'b1;
        i_miss_addr = 16'h5556;
        d_miss = 1'b1;
        d_miss_addr = 16'h4440;
        exp_fill(1'b1, 16'h4440, 76);
        exp_fill(1'b0, 16'h5556, 89);
        exp_fill(1'b1, 16'h6668, 102);
        goto(89);
        d_miss_addr = 16'h6668;
        goto(102);
        i_miss = 1'b0;
        goto(115);
        d_miss = 1'b0;

        // Store in IDLE
        goto(117);
        d_wr = 1'b1;
        d_wr_addr = 16'h0040;
        d_wr_data = 16'hBEEF;
        exp_wr(16'h0040, 16'hBEEF, 117);
        @(negedge clk);
        check("wr_ack_idle", {d_wr_ack, d_stall}, 2'b10);
        goto(118);
        d_wr = 1'b0;

        // Store and D miss raised during an I fill
        goto(120);
        i_miss = 1'b1;
        i_miss_addr = 16'h2000;
        exp_fill(1'b0, 16'h2000, 120);
        exp_wr(16'h0042, 16'h1234, 133);
        exp_fill(1'b1, 16'h3000, 134);
        goto(123);
        d_wr = 1'b1;
        d_wr_addr = 16'h0042;
        d_wr_data = 16'h1234;
        d_miss = 1'b1;
        d_miss_addr = 16'h3000;
        @(negedge clk);
        check("wr_ack_in_fill", {d_wr_ack, d_stall}, 2'b01);
        goto(133);
        i_miss = 1'b0;
        @(negedge clk);
        check("wr_ack_after_fill", d_wr_ack, 1'b1);
        goto(134);
        d_wr = 1'b0;
        goto(147);
        d_miss = 1'b0;

        // D miss dropped after the 3rd returned word
        goto(150);
        d_miss = 1'b1;
        d_miss_addr = 16'h4A5C;
        exp_fill(1'b1, 16'h4A5C, 150);
        goto(158);
        d_miss = 1'b0;
        goto(159);
        @(negedge clk);
        check("stall_no_abort", {d_stall, i_stall}, 2'b10);

        // Reset while the 5th read would issue
        goto(165);
        i_miss = 1'b1;
        i_miss_addr = 16'h5550;
        for (int k = 0; k < 4; k++) begin
            mem_q.push_back('{cyc: 166 + k, wr: 1'b0,
                              addr: 16'h5550 + 16'(2 * k), data: 16'h0});
        end
        goto(170);
        rst_n = 1'b0;
        i_miss = 1'b0;
        goto(171);
        rst_n = 1'b1;
        @(negedge clk);
        check("outs_after_midfill_reset", all_outs(), '0);
        for (int c = 172; c < 179; c++) begin
            goto(c);
            if (c == 175) stray_v = 1'b1;
            @(negedge clk);
            check($sformatf("stray@%0d", c),
                  {i_write_data, d_write_data, i_write_tag, d_write_tag},
                  4'b0000);
        end
        goto(179);
        stray_v = 1'b0;

        // Top-of-space block
        goto(182);
        i_miss = 1'b1;
        i_miss_addr = 16'hFFFF;
        exp_fill(1'b0, 16'hFFFF, 182);
        goto(195);
        i_miss = 1'b0;

        goto(200);
        @(negedge clk);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        check("fill_q_drained", 32'(fill_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog: got cycle %0d expected completion by 200", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
